// File: rtl/pic_pkg.sv
// Shared codes and state encoding for the 8259 write sequencer.
// Optional PIC_SEQ_ERROR_EN adds a sticky sequence-error flag on the top.
package pic_pkg;

  localparam logic [2:0] FLAG_ICW1 = 3'd0;
  localparam logic [2:0] FLAG_ICW2 = 3'd1;
  localparam logic [2:0] FLAG_ICW3 = 3'd2;
  localparam logic [2:0] FLAG_ICW4 = 3'd3;
  localparam logic [2:0] FLAG_OCW1 = 3'd4;
  localparam logic [2:0] FLAG_OCW2 = 3'd5;
  localparam logic [2:0] FLAG_OCW3 = 3'd6;
  localparam logic [2:0] FLAG_NONE = 3'd7;

  localparam logic [2:0] RSEL_IRR = 3'b001;
  localparam logic [2:0] RSEL_ISR = 3'b101;
  localparam logic [2:0] RSEL_IMR = 3'b011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_e;

  function automatic logic [2:0] read_sel(input logic a0, input logic ris);
    if (a0) return RSEL_IMR;
    return ris ? RSEL_ISR : RSEL_IRR;
  endfunction

endpackage

// File: rtl/pic_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle-high strobe shows no edge.
module pic_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic s1,
  output logic s2
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign s1 = s1_q;
  assign s2 = s2_q;

endmodule

// File: rtl/pic_cw_sequencer.sv
// 8259 control-word write sequencer: ICW ordering, OCW classification, read select.
// Define PIC_SEQ_ERROR_EN to add the sticky seq_error output for ignored writes.
module pic_cw_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       CS_n,
  input  logic       WR_n,
  input  logic       A0,
  input  logic [7:0] DIN,
  output logic       cw_valid,
  output logic [2:0] cw_flag,
  output logic [7:0] cw_data,
  output logic       poll_req,
  output logic       init_done,
  output logic [2:0] read_select
`ifdef PIC_SEQ_ERROR_EN
  ,
  output logic       seq_error
`endif
);

  logic wr_s1;
  logic wr_s2;

  pic_sync2 u_wr_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (WR_n),
    .s1     (wr_s1),
    .s2     (wr_s2)
  );

  state_e     state_q,    state_d;
  logic       cap_a0_q,   cap_a0_d;
  logic [7:0] cap_dat_q,  cap_dat_d;
  logic       cap_cs_q,   cap_cs_d;
  logic       acc_q,      acc_d;
  logic       acc_a0_q,   acc_a0_d;
  logic [7:0] acc_dat_q,  acc_dat_d;
  logic       sngl_q,     sngl_d;
  logic       ic4_q,      ic4_d;
  logic       ris_q,      ris_d;
  logic       cw_valid_q, cw_valid_d;
  logic [2:0] cw_flag_q,  cw_flag_d;
  logic [7:0] cw_data_q,  cw_data_d;
  logic       poll_q,     poll_d;
  logic       init_q,     init_d;
  logic       err_q,      err_d;

  logic       accept;
  logic       take;
  logic [2:0] flag;

  // Trailing edge of the strobe with a capture taken while it was low.
  assign accept = !wr_s2 && wr_s1 && cap_cs_q;

  always_comb begin
    state_d    = state_q;
    cap_a0_d   = cap_a0_q;
    cap_dat_d  = cap_dat_q;
    cap_cs_d   = cap_cs_q;
    acc_d      = accept;
    acc_a0_d   = acc_a0_q;
    acc_dat_d  = acc_dat_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    ris_d      = ris_q;
    cw_valid_d = 1'b0;
    cw_flag_d  = FLAG_NONE;
    cw_data_d  = cw_data_q;
    poll_d     = 1'b0;
    err_d      = err_q;
    take       = 1'b0;
    flag       = FLAG_NONE;

    if (!wr_s1 && !CS_n) begin
      cap_a0_d  = A0;
      cap_dat_d = DIN;
      cap_cs_d  = 1'b1;
    end
    if (accept) begin
      cap_cs_d  = 1'b0;
      acc_a0_d  = cap_a0_q;
      acc_dat_d = cap_dat_q;
    end

    // Decode stage: the word frozen on the accept edge is classified here.
    if (acc_q) begin
      if (!acc_a0_q && acc_dat_q[4]) begin
        take    = 1'b1;
        flag    = FLAG_ICW1;
        sngl_d  = acc_dat_q[1];
        ic4_d   = acc_dat_q[0];
        ris_d   = 1'b0;
        err_d   = 1'b0;
        state_d = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (acc_a0_q) begin
            take    = 1'b1;
            flag    = FLAG_ICW2;
            state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: if (acc_a0_q) begin
            take    = 1'b1;
            flag    = FLAG_ICW3;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (acc_a0_q) begin
            take    = 1'b1;
            flag    = FLAG_ICW4;
            state_d = READY;
          end
          READY: begin
            take = 1'b1;
            if (acc_a0_q) begin
              flag = FLAG_OCW1;
            end else if (!acc_dat_q[3]) begin
              flag = FLAG_OCW2;
            end else begin
              flag   = FLAG_OCW3;
              poll_d = acc_dat_q[2];
              if (acc_dat_q[1]) ris_d = acc_dat_q[0];
            end
          end
          default: take = 1'b0;
        endcase
      end

      if (take) begin
        cw_valid_d = 1'b1;
        cw_flag_d  = flag;
        cw_data_d  = acc_dat_q;
      end else begin
        err_d = 1'b1;
      end
    end

    init_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cap_a0_q   <= 1'b0;
      cap_dat_q  <= 8'h00;
      cap_cs_q   <= 1'b0;
      acc_q      <= 1'b0;
      acc_a0_q   <= 1'b0;
      acc_dat_q  <= 8'h00;
      sngl_q     <= 1'b0;
      ic4_q      <= 1'b0;
      ris_q      <= 1'b0;
      cw_valid_q <= 1'b0;
      cw_flag_q  <= FLAG_NONE;
      cw_data_q  <= 8'h00;
      poll_q     <= 1'b0;
      init_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_a0_q   <= cap_a0_d;
      cap_dat_q  <= cap_dat_d;
      cap_cs_q   <= cap_cs_d;
      acc_q      <= acc_d;
      acc_a0_q   <= acc_a0_d;
      acc_dat_q  <= acc_dat_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      ris_q      <= ris_d;
      cw_valid_q <= cw_valid_d;
      cw_flag_q  <= cw_flag_d;
      cw_data_q  <= cw_data_d;
      poll_q     <= poll_d;
      init_q     <= init_d;
      err_q      <= err_d;
    end
  end

  assign cw_valid    = cw_valid_q;
  assign cw_flag     = cw_flag_q;
  assign cw_data     = cw_data_q;
  assign poll_req    = poll_q;
  assign init_done   = init_q;
  assign read_select = read_sel(A0, ris_q);

`ifdef PIC_SEQ_ERROR_EN
  assign seq_error = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_pic_cw_sequencer.sv
// Scoreboard bench for pic_cw_sequencer; seq_error checks run when PIC_SEQ_ERROR_EN is defined.
module tb_pic_cw_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       CS_n = 1'b1;
  logic       WR_n = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       cw_valid;
  logic [2:0] cw_flag;
  logic [7:0] cw_data;
  logic       poll_req;
  logic       init_done;
  logic [2:0] read_select;
`ifdef PIC_SEQ_ERROR_EN
  logic       seq_error;
`endif

  int total = 0;
  int bad = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  pic_cw_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .CS_n       (CS_n),
    .WR_n       (WR_n),
    .A0         (A0),
    .DIN        (DIN),
    .cw_valid   (cw_valid),
    .cw_flag    (cw_flag),
    .cw_data    (cw_data),
    .poll_req   (poll_req),
    .init_done  (init_done)
`ifdef PIC_SEQ_ERROR_EN
    ,
    .read_select(read_select),
    .seq_error  (seq_error)
`else
    ,
    .read_select(read_select)
`endif
  );

  // Output monitor: every pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (cw_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: flag=%0d data=%h, none expected", cw_flag, cw_data);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if ({poll_req, cw_flag, cw_data} !== e) begin
          bad++;
          $display("FAIL pulse: got poll=%b flag=%0d data=%h, want poll=%b flag=%0d data=%h",
                   poll_req, cw_flag, cw_data, e[11], e[10:8], e[7:0]);
        end
      end
    end else begin
      total++;
      if (cw_flag !== 3'd7 || poll_req !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs: flag=%0d poll=%b, want flag=7 poll=0", cw_flag, poll_req);
      end
    end
  end

  task automatic do_write(input logic a0, input logic [7:0] d, input logic exp_v,
                          input logic [2:0] exp_f, input logic exp_p);
    @(negedge clk);
    CS_n = 1'b0; A0 = a0; DIN = d; WR_n = 1'b0;
    if (exp_v) sb.push_back({exp_p, exp_f, d});
    repeat (3) @(negedge clk);
    WR_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cw_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early: cw_valid=%b want 0 (data %h)", cw_valid, d);
    end
    @(posedge clk); #1;
    total++;
    if (cw_valid !== exp_v) begin
      bad++; $display("FAIL latency: cw_valid=%b want %b (data %h)", cw_valid, exp_v, d);
    end
    @(posedge clk); #1;
    total++;
    if (cw_valid !== 1'b0) begin
      bad++; $display("FAIL pulse_width: cw_valid=%b want 0 (data %h)", cw_valid, d);
    end
    CS_n = 1'b1; A0 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({cw_valid, cw_flag, cw_data, poll_req, init_done, read_select} !== {1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'b001}) begin
      bad++;
      $display("FAIL reset_values: valid=%b flag=%0d data=%h poll=%b init=%b rsel=%b, want 0 7 00 0 0 001",
               cw_valid, cw_flag, cw_data, poll_req, init_done, read_select);
    end
    A0 = 1'b1; #1;
    total++;
    if (read_select !== 3'b011) begin
      bad++; $display("FAIL reset_rsel_imr: rsel=%b want 011", read_select);
    end
    A0 = 1'b0;
`ifdef PIC_SEQ_ERROR_EN
    total++;
    if (seq_error !== 1'b0) begin
      bad++; $display("FAIL reset_seq_error: %b want 0", seq_error);
    end
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored_idle();
    do_write(1'b1, 8'hFF, 1'b0, 3'd7, 1'b0);
    do_write(1'b0, 8'h00, 1'b0, 3'd7, 1'b0);
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL idle_init_done: %b want 0", init_done);
    end
`ifdef PIC_SEQ_ERROR_EN
    total++;
    if (seq_error !== 1'b1) begin
      bad++; $display("FAIL seq_error_set: %b want 1", seq_error);
    end
`endif
  endtask

  task automatic test_init_single();
    do_write(1'b0, 8'h13, 1'b1, 3'd0, 1'b0);
`ifdef PIC_SEQ_ERROR_EN
    total++;
    if (seq_error !== 1'b0) begin
      bad++; $display("FAIL seq_error_clear: %b want 0", seq_error);
    end
`endif
    do_write(1'b0, 8'h05, 1'b0, 3'd7, 1'b0);
    do_write(1'b1, 8'h20, 1'b1, 3'd1, 1'b0);
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL single_init_early: %b want 0", init_done);
    end
    do_write(1'b1, 8'h01, 1'b1, 3'd3, 1'b0);
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL single_init_done: %b want 1", init_done);
    end
  endtask

  task automatic test_ocw();
    do_write(1'b1, 8'hFB, 1'b1, 3'd4, 1'b0);
    do_write(1'b0, 8'h20, 1'b1, 3'd5, 1'b0);
    do_write(1'b0, 8'h0C, 1'b1, 3'd6, 1'b1);
    total++;
    if (read_select !== 3'b001) begin
      bad++; $display("FAIL poll_ris_kept: rsel=%b want 001", read_select);
    end
    do_write(1'b0, 8'h0B, 1'b1, 3'd6, 1'b0);
    total++;
    if (read_select !== 3'b101) begin
      bad++; $display("FAIL rsel_isr: rsel=%b want 101", read_select);
    end
    A0 = 1'b1; #1;
    total++;
    if (read_select !== 3'b011) begin
      bad++; $display("FAIL rsel_imr: rsel=%b want 011", read_select);
    end
    A0 = 1'b0;
    do_write(1'b0, 8'h0C, 1'b1, 3'd6, 1'b1);
    total++;
    if (read_select !== 3'b101 || cw_data !== 8'h0C) begin
      bad++; $display("FAIL ris_sticky: rsel=%b data=%h want 101 0c", read_select, cw_data);
    end
  endtask

  task automatic test_init_cascade();
    do_write(1'b0, 8'h11, 1'b1, 3'd0, 1'b0);
    total++;
    if (init_done !== 1'b0 || read_select !== 3'b001) begin
      bad++; $display("FAIL restart: init=%b rsel=%b want 0 001", init_done, read_select);
    end
    do_write(1'b1, 8'h20, 1'b1, 3'd1, 1'b0);
    do_write(1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL cascade_init_early: %b want 0", init_done);
    end
    do_write(1'b1, 8'h01, 1'b1, 3'd3, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (init_done !== 1'b1 || cw_data !== 8'h01) begin
      bad++; $display("FAIL cascade_done: init=%b data=%h want 1 01", init_done, cw_data);
    end
  endtask

  task automatic test_reset_mid();
    do_write(1'b0, 8'h11, 1'b1, 3'd0, 1'b0);
    do_write(1'b1, 8'h20, 1'b1, 3'd1, 1'b0);
    @(negedge clk);
    CS_n = 1'b0; A0 = 1'b1; DIN = 8'h04; WR_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0; #1;
    total++;
    if ({cw_valid, cw_flag, cw_data, poll_req, init_done} !== {1'b0, 3'd7, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: valid=%b flag=%0d data=%h poll=%b init=%b, want 0 7 00 0 0",
               cw_valid, cw_flag, cw_data, poll_req, init_done);
    end
    @(negedge clk);
    WR_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1; CS_n = 1'b1; A0 = 1'b0;
    repeat (6) @(negedge clk);
    do_write(1'b0, 8'h13, 1'b1, 3'd0, 1'b0);
    do_write(1'b1, 8'h20, 1'b1, 3'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ignored_idle();
    test_init_single();
    test_ocw();
    test_init_cascade();
    test_reset_mid();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL missing_pulses: %0d outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic_cw_sequencer.md
# pic_cw_sequencer

Synchronous write-sequencing controller for the 8259 PIC core. It samples the asynchronous CPU write strobe and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization order. After initialization it classifies writes as OCW1/OCW2/OCW3 and issues one-cycle command pulses carrying the control-word code and data to the control-logic block. It also holds the OCW3 read-register selection and drives the read-select code used when the CPU reads status.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- CS_n  in  1  chip select from bus, asynchronous
- WR_n  in  1  write strobe from bus, asynchronous
- A0  in  1  address bit from bus
- DIN  in  8  data bus write value
- cw_valid  out  1  one-cycle pulse: a control word was accepted
- cw_flag  out  3  word code: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1, 5 OCW2, 6 OCW3, 7 none
- cw_data  out  8  data of the accepted word, held until the next accept
- poll_req  out  1  one-cycle pulse, coincident with cw_valid, when an OCW3 has P=1
- init_done  out  1  high in READY
- read_select  out  3  3'b011 IMR when A0=1; otherwise {ris,1'b0,1'b1}, i.e. 001 IRR or 101 ISR

## Operation
- WR_n passes through a 2-flop synchronizer (wr_s1, wr_s2).
- While wr_s1=0 and CS_n=0, every clk: cap_a0←A0, cap_d←DIN, cap_cs←1. cap_cs clears after each accept.
- A write is recognized when wr_s2=0, wr_s1=1 and cap_cs=1. That is the trailing edge of the strobe, using the last captured A0/DIN.
- ICW1 = A0=0 and D4=1. It is accepted in every state and:
  - latches sngl←D1 and ic4←D0;
  - clears ris;
  - sets the next state to WAIT_ICW2.
- States:
  - IDLE (reset): only ICW1 is accepted.
  - WAIT_ICW2: A0=1 → ICW2. Next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW3: A0=1 → ICW3. Next state is WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW4: A0=1 → ICW4. Next state is READY.
  - READY:
    - A0=1 → OCW1.
    - A0=0, D4=0, D3=0 → OCW2.
    - A0=0, D4=0, D3=1 → OCW3. If D1 (RR)=1, ris←D0; otherwise ris is unchanged. poll_req←D2.
- Ignored writes produce no pulse and no state change:
  - any non-ICW1 write in IDLE;
  - any A0=0 non-ICW1 write in a WAIT state.
- read_select is combinational from raw A0 and ris.

## Timing
- Reset values:
  - state IDLE, cw_valid 0, cw_flag 3'b111, cw_data 0;
  - poll_req 0, init_done 0;
  - ris 0, so read_select is 001 when A0=0;
  - synchronizer flops 1, cap_* 0.
- Latency from WR_n rise to cw_valid:
  - edge 1: wr_s1=1;
  - edge 2: wr_s2 still 0, so the accept is decoded combinationally;
  - edge 3: cw_valid, cw_flag, cw_data and the next state are registered.
  - cw_valid is high for exactly one cycle. cw_flag returns to 3'b111 on the following edge.
- A minimum WR_n low time of 2 clk is required; shorter strobes may be missed.
- Back-to-back writes spaced ≥4 clk are each accepted.
- An ICW1 during initialization or READY restarts the sequence in the same accept cycle. init_done drops on that edge.
- reset_n asserted mid-sequence → immediate return to reset values. A strobe already in flight is discarded.
- CS_n rising during a low strobe does not cancel a capture already taken.

## Configuration
- PIC_SEQ_ERROR_EN defined:
  - adds output seq_error (1 bit), reset value 0;
  - set on the accept-decode edge of any ignored write;
  - cleared by an accepted ICW1 or by reset;
  - sticky otherwise.
- PIC_SEQ_ERROR_EN undefined: the port and its logic are absent, and ignored writes are silently dropped.

## Structure
- Package pic_pkg holds:
  - localparams FLAG_ICW1..FLAG_OCW3 and FLAG_NONE;
  - read-select codes RSEL_IRR, RSEL_ISR, RSEL_IMR;
  - the state enum IDLE/WAIT_ICW2/WAIT_ICW3/WAIT_ICW4/READY.
- Sub-module pic_sync2: a 2-flop synchronizer with async active-low reset to 1, used for WR_n.

## Test plan
- ICW1=8'h13 (SNGL=1, IC4=1), then ICW2=8'h20, then ICW4=8'h01 → flags 0,1,3; init_done=1 after the third accept; no ICW3 pulse.
- ICW1=8'h11 (cascade, IC4=1), then A0=1 writes 8'h20, 8'h04, 8'h01 → flags 0,1,2,3; cw_data matches each word; each cw_valid pulse is 1 clk wide, 3 clk after WR_n rise.
- READY: A0=1 8'hFB → flag 4; A0=0 8'h20 → flag 5; A0=0 8'h0B → flag 6, then read_select=101 with A0=0 and 011 with A0=1.
- READY: A0=0 8'h0C → flag 6, poll_req=1 for 1 clk, ris unchanged (read_select stays 001).
- IDLE: A0=1 8'hFF → no cw_valid, state IDLE, seq_error=1 (macro on). A subsequent ICW1 clears seq_error.
- Mid-sequence after ICW2: reset_n pulsed low → all outputs at reset values. Then a new ICW1 restarts normally with flag 0.
